// File: rtl/ad_emu_pkg.sv
// Shared constants for the serial ADC emulator: mode codes, register map, LFSR and FSM state type.
// Pure declarations, no logic; the LFSR step is only referenced when AD_EMU_LFSR_EN is defined.
package ad_emu_pkg;

    localparam logic [1:0] MODE_CONST = 2'd0;
    localparam logic [1:0] MODE_RAMP  = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;

    localparam logic [7:0] REG_MODE      = 8'h00;
    localparam logic [7:0] REG_CONST_LO  = 8'h01;
    localparam logic [7:0] REG_CONST_HI  = 8'h02;
    localparam logic [7:0] REG_STEP      = 8'h03;
    localparam logic [7:0] REG_FRAME_CNT = 8'h04;
    localparam logic [7:0] REG_STATUS    = 8'h05;

    localparam logic [15:0] CONST_RST = 16'h8000;
    localparam logic [7:0]  STEP_RST  = 8'h01;

    // Fibonacci, right shift: taps 16,14,13,11 sit at bits 0,2,3,5 of the state.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/ad_emu_if.sv
// Serial ADC link (cs_n/sclk/sdata) plus the fx register bus, grouped for the emulator port.
// Plain wires, no latency or flow control of its own.
interface ad_emu_if;
    logic        cs_n;
    logic        sclk;
    logic        sdata;
    logic        sdata_oe;
    logic [5:0]  dev_id;
    logic        fx_wr;
    logic [21:0] fx_waddr;
    logic [7:0]  fx_data;
    logic        fx_rd;
    logic [21:0] fx_raddr;
    logic [7:0]  fx_q;

    modport slave (
        input  cs_n, sclk, dev_id, fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
        output sdata, sdata_oe, fx_q
    );

    modport master (
        output cs_n, sclk, dev_id, fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
        input  sdata, sdata_oe, fx_q
    );
endinterface

// File: rtl/ad_emu_pattern.sv
// Sample source (const/ramp/LFSR with AD_EMU_LFSR_EN) holding mode/const/step; updates 1 cycle after strobe.
// No backpressure: advance and register writes are single-cycle strobes, a mode write beats an advance.
module ad_emu_pattern
    import ad_emu_pkg::*;
(
    input  logic        i_clk_sys,
    input  logic        i_rst,
    input  logic        i_adv,
    input  logic        i_mode_wr,
    input  logic        i_const_lo_wr,
    input  logic        i_const_hi_wr,
    input  logic        i_step_wr,
    input  logic [7:0]  i_wdat,
    output logic [1:0]  o_mode,
    output logic [15:0] o_const,
    output logic [7:0]  o_step,
    output logic [15:0] o_sample
);

    logic [1:0]  r_mode;
    logic [15:0] r_const;
    logic [7:0]  r_step;
    logic [15:0] r_sample;
    logic [15:0] w_sample_nxt;

    always_comb begin
        w_sample_nxt = r_sample;
        if (i_mode_wr) begin
            w_sample_nxt = r_const;
            if (i_wdat[1:0] == MODE_RAMP) begin
                w_sample_nxt = 16'h0000;
            end
`ifdef AD_EMU_LFSR_EN
            if (i_wdat[1:0] == MODE_LFSR) begin
                w_sample_nxt = LFSR_SEED;
            end
`endif
        end else if (i_adv) begin
            w_sample_nxt = r_const;
            if (r_mode == MODE_RAMP) begin
                w_sample_nxt = r_sample + {8'h00, r_step};
            end
`ifdef AD_EMU_LFSR_EN
            if (r_mode == MODE_LFSR) begin
                w_sample_nxt = lfsr_next(r_sample);
            end
`endif
        end
    end

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            r_mode   <= MODE_RAMP;
            r_const  <= CONST_RST;
            r_step   <= STEP_RST;
            r_sample <= 16'h0000;
        end else begin
            r_sample <= w_sample_nxt;
            if (i_mode_wr)     r_mode         <= i_wdat[1:0];
            if (i_const_lo_wr) r_const[7:0]   <= i_wdat;
            if (i_const_hi_wr) r_const[15:8]  <= i_wdat;
            if (i_step_wr)     r_step         <= i_wdat;
        end
    end

    assign o_mode   = r_mode;
    assign o_const  = r_const;
    assign o_step   = r_step;
    assign o_sample = r_sample;

endmodule

// File: rtl/ad_emu_tx.sv
// Serial ADC emulator transmit end; sdata follows a raw sclk fall within 3 clk_sys, fx_q 1 cycle after fx_rd.
// No backpressure: the reader owns cs_n/sclk timing; optional LFSR source via AD_EMU_LFSR_EN.
module ad_emu_tx
    import ad_emu_pkg::*;
#(
    parameter int N_LEAD  = 4,
    parameter int N_TRAIL = 4
)
(
    input  logic     i_clk_sys,
    input  logic     i_rst,
    ad_emu_if.slave  io_emu
);

    localparam int FRAME_LEN = N_LEAD + 16 + N_TRAIL;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_LEAD + 16);

    // Synchronizers reset to the idle-high level so release from reset is not seen as an edge.
    logic [1:0] r_cs_sync;
    logic [1:0] r_sclk_sync;
    logic       r_cs_prev;
    logic       r_sclk_prev;
    logic       w_cs_fall;
    logic       w_cs_rise;
    logic       w_sclk_fall;

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            r_cs_sync   <= 2'b11;
            r_sclk_sync <= 2'b11;
            r_cs_prev   <= 1'b1;
            r_sclk_prev <= 1'b1;
        end else begin
            r_cs_sync   <= {r_cs_sync[0], io_emu.cs_n};
            r_sclk_sync <= {r_sclk_sync[0], io_emu.sclk};
            r_cs_prev   <= r_cs_sync[1];
            r_sclk_prev <= r_sclk_sync[1];
        end
    end

    assign w_cs_fall   = r_cs_prev & ~r_cs_sync[1];
    assign w_cs_rise   = ~r_cs_prev & r_cs_sync[1];
    assign w_sclk_fall = r_sclk_prev & ~r_sclk_sync[1];

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_load;
    logic                   w_shift;
    logic                   w_done;
    logic                   w_abort;
    logic [FRAME_LEN-1:0]   r_shreg;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic                   r_sdata;
    logic                   r_sdata_oe;
    logic [15:0]            w_sample;

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = ST_SHIFT;
                    w_load      = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                    if (r_bit_cnt >= CNT_FULL) w_done  = 1'b1;
                    else                       w_abort = 1'b1;
                end else if (w_sclk_fall) begin
                    w_shift = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Zero fill on shift means sclk beyond the frame keeps sending 0.
    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_sdata    <= 1'b0;
            r_sdata_oe <= 1'b0;
        end else if (w_load) begin
            r_shreg    <= {{N_LEAD{1'b0}}, w_sample, {N_TRAIL{1'b0}}};
            r_bit_cnt  <= '0;
            r_sdata    <= 1'b0;
            r_sdata_oe <= 1'b1;
        end else if (w_shift) begin
            r_sdata <= r_shreg[FRAME_LEN-1];
            r_shreg <= {r_shreg[FRAME_LEN-2:0], 1'b0};
            if (r_bit_cnt != CNT_MAX) r_bit_cnt <= r_bit_cnt + 1'b1;
        end else if (w_done || w_abort) begin
            r_sdata    <= 1'b0;
            r_sdata_oe <= 1'b0;
        end
    end

    logic       w_wr_hit;
    logic       w_rd_hit;
    logic [7:0] w_wr_reg;
    logic [7:0] w_rd_reg;
    logic       w_trunc_clr;
    logic       r_trunc;
    logic [7:0] r_frame_cnt;
    logic [7:0] r_fx_q;
    logic [7:0] w_rd_val;
    logic [1:0] w_mode;
    logic [15:0] w_const;
    logic [7:0] w_step;
    logic       w_unused;

    assign w_wr_hit    = io_emu.fx_wr && (io_emu.fx_waddr[21:16] == io_emu.dev_id);
    assign w_rd_hit    = io_emu.fx_rd && (io_emu.fx_raddr[21:16] == io_emu.dev_id);
    assign w_wr_reg    = io_emu.fx_waddr[7:0];
    assign w_rd_reg    = io_emu.fx_raddr[7:0];
    assign w_trunc_clr = w_wr_hit && (w_wr_reg == REG_STATUS) && io_emu.fx_data[0];
    assign w_unused    = ^{io_emu.fx_waddr[15:8], io_emu.fx_raddr[15:8]};

    ad_emu_pattern u_pattern (
        .i_clk_sys     (i_clk_sys),
        .i_rst         (i_rst),
        .i_adv         (w_done),
        .i_mode_wr     (w_wr_hit && (w_wr_reg == REG_MODE)),
        .i_const_lo_wr (w_wr_hit && (w_wr_reg == REG_CONST_LO)),
        .i_const_hi_wr (w_wr_hit && (w_wr_reg == REG_CONST_HI)),
        .i_step_wr     (w_wr_hit && (w_wr_reg == REG_STEP)),
        .i_wdat        (io_emu.fx_data),
        .o_mode        (w_mode),
        .o_const       (w_const),
        .o_step        (w_step),
        .o_sample      (w_sample)
    );

    // A new truncation outranks a simultaneous clear.
    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            r_trunc     <= 1'b0;
            r_frame_cnt <= 8'h00;
            r_fx_q      <= 8'h00;
        end else begin
            r_trunc <= w_abort | (r_trunc & ~w_trunc_clr);
            if (w_done) r_frame_cnt <= r_frame_cnt + 8'd1;
            r_fx_q <= w_rd_hit ? w_rd_val : 8'h00;
        end
    end

    always_comb begin
        w_rd_val = 8'h00;
        case (w_rd_reg)
            REG_MODE:      w_rd_val = {6'h00, w_mode};
            REG_CONST_LO:  w_rd_val = w_const[7:0];
            REG_CONST_HI:  w_rd_val = w_const[15:8];
            REG_STEP:      w_rd_val = w_step;
            REG_FRAME_CNT: w_rd_val = r_frame_cnt;
            REG_STATUS:    w_rd_val = {6'h00, (r_state == ST_SHIFT), r_trunc};
            default:       w_rd_val = 8'h00;
        endcase
    end

    assign io_emu.sdata    = r_sdata;
    assign io_emu.sdata_oe = r_sdata_oe;
    assign io_emu.fx_q     = r_fx_q;

endmodule

// File: tb/tb_ad_emu_tx.sv
// Directed bench for ad_emu_tx: 50 MHz clk_sys, 4 MHz sclk frames, fx register access, reset abort.
module tb_ad_emu_tx;

    localparam logic [5:0] DEV   = 6'h15;
    localparam logic [5:0] OTHER = 6'h2A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #10 clk = ~clk;

    ad_emu_if bus ();

    ad_emu_tx dut (
        .i_clk_sys (clk),
        .i_rst     (rst),
        .io_emu    (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fx_write(input logic [7:0] a, input logic [7:0] d, input logic [5:0] id);
        @(negedge clk);
        bus.fx_wr    = 1'b1;
        bus.fx_waddr = {id, 8'h00, a};
        bus.fx_data  = d;
        @(negedge clk);
        bus.fx_wr    = 1'b0;
    endtask

    task automatic fx_read(input logic [7:0] a, input logic [5:0] id, output logic [7:0] q);
        @(negedge clk);
        bus.fx_rd    = 1'b1;
        bus.fx_raddr = {id, 8'h00, a};
        @(negedge clk);
        bus.fx_rd    = 1'b0;
        q = bus.fx_q;
    endtask

    task automatic frame_begin();
        bus.cs_n = 1'b0;
        #200;
    endtask

    task automatic frame_bits(input int n, output logic [23:0] cap);
        cap = '0;
        for (int i = 0; i < n; i++) begin
            bus.sclk = 1'b0;
            #125;
            cap = {cap[22:0], bus.sdata};
            bus.sclk = 1'b1;
            #125;
        end
    endtask

    task automatic frame_end();
        bus.cs_n = 1'b1;
        #200;
    endtask

    task automatic send_frame(input string tag, input logic [15:0] word);
        logic [23:0] cap;
        frame_begin();
        frame_bits(24, cap);
        check({tag, "_oe_in"}, 32'(bus.sdata_oe), 32'd1);
        frame_end();
        check(tag, 32'(cap), 32'({4'h0, word, 4'h0}));
        check({tag, "_oe_out"}, 32'(bus.sdata_oe), 32'd0);
    endtask

    function automatic logic [15:0] model_lfsr(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    logic [7:0]  q;
    logic [23:0] cap;
    logic [15:0] lf;

    initial begin
        bus.cs_n     = 1'b1;
        bus.sclk     = 1'b1;
        bus.dev_id   = DEV;
        bus.fx_wr    = 1'b0;
        bus.fx_waddr = '0;
        bus.fx_data  = '0;
        bus.fx_rd    = 1'b0;
        bus.fx_raddr = '0;
        lf           = 16'h0000;

        #55;
        check("rst_sdata", 32'(bus.sdata), 32'd0);
        check("rst_oe", 32'(bus.sdata_oe), 32'd0);
        check("rst_fxq", 32'(bus.fx_q), 32'd0);
        rst = 1'b0;
        fx_read(8'h00, DEV, q); check("rst_mode", 32'(q), 32'h01);
        fx_read(8'h02, DEV, q); check("rst_const_hi", 32'(q), 32'h80);
        fx_read(8'h03, DEV, q); check("rst_step", 32'(q), 32'h01);

        // Ramp, step 1
        send_frame("ramp0", 16'h0000);
        send_frame("ramp1", 16'h0001);
        send_frame("ramp2", 16'h0002);
        fx_read(8'h04, DEV, q); check("fcnt3", 32'(q), 32'h03);

        // Truncated frame holds sample and frame count
        frame_begin();
        fx_read(8'h05, DEV, q); check("status_busy", 32'(q), 32'h02);
        frame_bits(10, cap);
        frame_end();
        fx_read(8'h05, DEV, q); check("status_trunc", 32'(q), 32'h01);
        fx_read(8'h04, DEV, q); check("fcnt_trunc", 32'(q), 32'h03);
        send_frame("ramp_repeat", 16'h0003);
        fx_read(8'h04, DEV, q); check("fcnt4", 32'(q), 32'h04);
        fx_write(8'h05, 8'h01, DEV);
        fx_read(8'h05, DEV, q); check("status_clr", 32'(q), 32'h00);

        // Const mode
        fx_write(8'h01, 8'h34, DEV);
        fx_write(8'h02, 8'h12, DEV);
        fx_write(8'h00, 8'h00, DEV);
        send_frame("const_a", 16'h1234);
        send_frame("const_b", 16'h1234);

        // fx decode
        fx_read(8'h04, DEV, q); check("rd_hit", 32'(q), 32'h06);
        @(negedge clk); check("rd_after", 32'(bus.fx_q), 32'h00);
        fx_read(8'h04, OTHER, q); check("rd_miss", 32'(q), 32'h00);
        fx_read(8'h07, DEV, q); check("rd_unmapped", 32'(q), 32'h00);
        fx_write(8'h03, 8'h55, OTHER);
        fx_write(8'h00, 8'h01, OTHER);
        fx_read(8'h03, DEV, q); check("wr_miss_step", 32'(q), 32'h01);
        fx_read(8'h00, DEV, q); check("wr_miss_mode", 32'(q), 32'h00);
        fx_read(8'h01, DEV, q); check("const_lo", 32'(q), 32'h34);

        // Reset mid-frame
        frame_begin();
        frame_bits(12, cap);
        check("pre_rst_bits", 32'(cap[11:0]), 32'h012);
        check("pre_rst_oe", 32'(bus.sdata_oe), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_sdata", 32'(bus.sdata), 32'd0);
        check("mid_rst_oe", 32'(bus.sdata_oe), 32'd0);
        bus.cs_n = 1'b1;
        #100;
        rst = 1'b0;
        fx_read(8'h00, DEV, q); check("post_rst_mode", 32'(q), 32'h01);
        fx_read(8'h01, DEV, q); check("post_rst_const_lo", 32'(q), 32'h00);
        fx_read(8'h02, DEV, q); check("post_rst_const_hi", 32'(q), 32'h80);
        fx_read(8'h04, DEV, q); check("post_rst_fcnt", 32'(q), 32'h00);
        fx_read(8'h05, DEV, q); check("post_rst_status", 32'(q), 32'h00);
        send_frame("post_rst_word", 16'h0000);
        fx_read(8'h04, DEV, q); check("post_rst_fcnt1", 32'(q), 32'h01);

        // Mode 2
`ifdef AD_EMU_LFSR_EN
        fx_write(8'h00, 8'h02, DEV);
        lf = 16'hACE1;
        send_frame("lfsr0", lf);
        lf = model_lfsr(lf);
        send_frame("lfsr1", lf);
        lf = model_lfsr(lf);
        send_frame("lfsr2", lf);
`else
        fx_write(8'h01, 8'hAA, DEV);
        fx_write(8'h02, 8'h00, DEV);
        fx_write(8'h00, 8'h02, DEV);
        send_frame("mode2_a", 16'h00AA);
        send_frame("mode2_b", 16'h00AA);
        lf = model_lfsr(16'hACE1);
        check("mode2_not_lfsr", 32'(lf == 16'h00AA), 32'd0);
`endif
        fx_read(8'h00, DEV, q); check("mode2_rd", 32'(q), 32'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
